byte_addressable_memory: RTL and testbench

- Parametrised successor to the multi-cycle core's unified instruction/data memory.
- Byte-addressed, 32-bit wide, with RISC-V load/store sizing (LB/LH/LW/LBU/LHU/SB/SH/SW) and sign/zero extension.
- Valid/ready request handshake with configurable read latency, and a sequential post-reset clear sweep.
- The multi-cycle control FSM uses it for both instruction fetch and load/store.

---
 rtl/byte_addressable_memory_pkg.sv | 55 +++++
 rtl/byte_addressable_memory_byte_lane_ram.sv | 37 +++
 rtl/byte_addressable_memory.sv | 227 ++++++++++++++++++++++
 tb/tb_byte_addressable_memory.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/byte_addressable_memory_pkg.sv
// Shared encodings, FSM states and byte-lane helpers for byte_addressable_memory.
package byte_addressable_memory_pkg;

   localparam logic [2:0] SIZE_B  = 3'b000;
   localparam logic [2:0] SIZE_H  = 3'b001;
   localparam logic [2:0] SIZE_W  = 3'b010;
   localparam logic [2:0] SIZE_BU = 3'b100;
   localparam logic [2:0] SIZE_HU = 3'b101;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Unknown sizes fall through to a full-word access.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] mask;
      case (size)
         SIZE_B, SIZE_BU: mask = 4'b0001 << lane;
         SIZE_H, SIZE_HU: mask = lane[1] ? 4'b1100 : 4'b0011;
         default:         mask = 4'b1111;
      endcase
      return mask;
   endfunction

   function automatic logic [31:0] store_align(input logic [2:0] size, input logic [31:0] data);
      logic [31:0] aligned;
      case (size)
         SIZE_B, SIZE_BU: aligned = {4{data[7:0]}};
         SIZE_H, SIZE_HU: aligned = {2{data[15:0]}};
         default:         aligned = data;
      endcase
      return aligned;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [31:0] shifted;
      logic [15:0] half;
      logic [31:0] result;
      shifted = word >> {lane, 3'b000};
      half    = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_B:  result = {{24{shifted[7]}}, shifted[7:0]};
         SIZE_BU: result = {24'h000000, shifted[7:0]};
         SIZE_H:  result = {{16{half[15]}}, half};
         SIZE_HU: result = {16'h0000, half};
         default: result = word;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/byte_addressable_memory_byte_lane_ram.sv
// MEMORY_SIZE x 32 storage with per-byte write enables and a registered read port.
module byte_lane_ram #(
   parameter int MEMORY_SIZE = 256,
   parameter int IDX_W       = $clog2(MEMORY_SIZE)
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [MEMORY_SIZE];
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   // Read word is held between reads so the response stage can pick it up late.
   always_comb begin
      rdata_d = re ? mem_q[idx] : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
               mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
            end
         end
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/byte_addressable_memory.sv
// Byte-addressed 32-bit memory with RISC-V load/store sizing, valid/ready handshake and
// post-reset clear sweep. Define BYTE_MEM_ACCESS_FAULT_EN to enable access-fault checking.
module byte_addressable_memory
   import byte_addressable_memory_pkg::*;
#(
   parameter int MEMORY_SIZE  = 256,
   parameter int ADDR_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic                  WriteEnable,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [31:0]           WriteData,
   input  logic [2:0]            Size,
   output logic                  RespValid,
   output logic [31:0]           ReadData,
   output logic                  Fault,
   output logic                  InitDone
);

   localparam int               IDX_W    = $clog2(MEMORY_SIZE);
   localparam int               IDXF_W   = ADDR_WIDTH - 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEMORY_SIZE - 1);
   localparam logic [2:0]       LAT_INIT = 3'(READ_LATENCY - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   clr_q, clr_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [2:0]         size_q, size_d;
   logic [1:0]         lane_q, lane_d;
   logic               we_q, we_d;
   logic               flt_q, flt_d;
   logic               req_ready_q, req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic [31:0]        read_data_q, read_data_d;
   logic               fault_q, fault_d;
   logic               init_done_q, init_done_d;

   logic               accept_s;
   logic [IDXF_W-1:0]  idx_full_s;
   logic [IDX_W-1:0]   idx_wrap_s;
   logic               req_fault_s;
   logic               ram_we_s;
   logic               ram_re_s;
   logic [3:0]         ram_be_s;
   logic [IDX_W-1:0]   ram_idx_s;
   logic [31:0]        ram_wdata_s;
   logic [31:0]        ram_rdata_s;

   assign accept_s   = ReqValid && (state_q == IDLE);
   assign idx_full_s = Address[ADDR_WIDTH-1:2];
   assign idx_wrap_s = IDX_W'(idx_full_s % IDXF_W'(MEMORY_SIZE));

`ifdef BYTE_MEM_ACCESS_FAULT_EN
   logic misalign_s;
   logic illegal_s;

   // Misalignment, out-of-range index and unsupported sizes all fault.
   always_comb begin
      case (Size)
         SIZE_B, SIZE_BU: begin
            misalign_s = 1'b0;
            illegal_s  = 1'b0;
         end
         SIZE_H, SIZE_HU: begin
            misalign_s = Address[0];
            illegal_s  = 1'b0;
         end
         SIZE_W: begin
            misalign_s = (Address[1:0] != 2'b00);
            illegal_s  = 1'b0;
         end
         default: begin
            misalign_s = 1'b0;
            illegal_s  = 1'b1;
         end
      endcase
      req_fault_s = misalign_s || illegal_s || (WriteEnable && Size[2])
                    || (idx_full_s >= IDXF_W'(MEMORY_SIZE));
   end
`else
   assign req_fault_s = 1'b0;
`endif

   always_comb begin
      ram_we_s    = 1'b0;
      ram_re_s    = 1'b0;
      ram_be_s    = 4'b0000;
      ram_idx_s   = idx_wrap_s;
      ram_wdata_s = store_align(Size, WriteData);
      case (state_q)
         CLEAR: begin
            ram_we_s    = 1'b1;
            ram_be_s    = 4'b1111;
            ram_idx_s   = clr_q;
            ram_wdata_s = 32'h0000_0000;
         end
         IDLE: begin
            ram_we_s = accept_s && WriteEnable && !req_fault_s;
            ram_re_s = accept_s && !WriteEnable;
            ram_be_s = lane_mask(Size, Address[1:0]);
         end
         default: begin
            ram_we_s = 1'b0;
         end
      endcase
   end

   byte_lane_ram #(
      .MEMORY_SIZE (MEMORY_SIZE),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we_s),
      .re    (ram_re_s),
      .be    (ram_be_s),
      .idx   (ram_idx_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      lane_d  = lane_q;
      we_d    = we_q;
      flt_d   = flt_q;
      case (state_q)
         CLEAR: begin
            if (clr_q == LAST_IDX) begin
               clr_d   = '0;
               state_d = IDLE;
            end else begin
               clr_d = clr_q + 1'b1;
            end
         end
         IDLE: begin
            if (accept_s) begin
               size_d  = Size;
               lane_d  = Address[1:0];
               we_d    = WriteEnable;
               flt_d   = req_fault_s;
               cnt_d   = LAT_INIT;
               state_d = (READ_LATENCY == 1) ? RESP : BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = RESP;
            end else begin
               state_d = BUSY;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // Outputs are registered; the response becomes visible as RESP is left.
   always_comb begin
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_q == RESP);
      fault_d      = (state_q == RESP) && flt_q;
      init_done_d  = init_done_q || ((state_q == CLEAR) && (state_d == IDLE));
      read_data_d  = read_data_q;
      if (state_q == RESP) begin
         if (flt_q) begin
            read_data_d = 32'h0000_0000;
         end else if (!we_q) begin
            read_data_d = load_extend(size_q, lane_q, ram_rdata_s);
         end else begin
            read_data_d = read_data_q;
         end
      end else begin
         read_data_d = read_data_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= CLEAR;
         clr_q        <= '0;
         cnt_q        <= 3'd0;
         size_q       <= 3'd0;
         lane_q       <= 2'd0;
         we_q         <= 1'b0;
         flt_q        <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         read_data_q  <= 32'h0000_0000;
         fault_q      <= 1'b0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_q        <= clr_d;
         cnt_q        <= cnt_d;
         size_q       <= size_d;
         lane_q       <= lane_d;
         we_q         <= we_d;
         flt_q        <= flt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         read_data_q  <= read_data_d;
         fault_q      <= fault_d;
         init_done_q  <= init_done_d;
      end
   end

   assign ReqReady  = req_ready_q;
   assign RespValid = resp_valid_q;
   assign ReadData  = read_data_q;
   assign Fault     = fault_q;
   assign InitDone  = init_done_q;

endmodule

// File: tb/tb_byte_addressable_memory.sv
// Directed, table-driven bench: one DUT at READ_LATENCY=1, one at READ_LATENCY=4.
module tb_byte_addressable_memory;
   import byte_addressable_memory_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        valid, rdy, we, rv, flt_o, init;
   logic [31:0] addr, wd, rdata;
   logic [2:0]  size;
   logic        l4_valid, l4_rdy, l4_we, l4_rv, l4_flt, l4_init;
   logic [31:0] l4_addr, l4_wd, l4_rdata;
   logic [2:0]  l4_size;

   int n_vec = 0;
   int n_err = 0;

   byte_addressable_memory #(.MEMORY_SIZE(256), .ADDR_WIDTH(32), .READ_LATENCY(1)) dut (
      .CLK(clk), .RESET(rst), .ReqValid(valid), .ReqReady(rdy), .WriteEnable(we),
      .Address(addr), .WriteData(wd), .Size(size), .RespValid(rv), .ReadData(rdata),
      .Fault(flt_o), .InitDone(init)
   );

   byte_addressable_memory #(.MEMORY_SIZE(256), .ADDR_WIDTH(32), .READ_LATENCY(4)) dut4 (
      .CLK(clk), .RESET(rst), .ReqValid(l4_valid), .ReqReady(l4_rdy), .WriteEnable(l4_we),
      .Address(l4_addr), .WriteData(l4_wd), .Size(l4_size), .RespValid(l4_rv),
      .ReadData(l4_rdata), .Fault(l4_flt), .InitDone(l4_init)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wd;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_flt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t ld(input logic [31:0] a, input logic [2:0] s, input logic [31:0] e);
      vec_t v;
      v.we = 1'b0; v.addr = a; v.size = s; v.wd = 32'h0;
      v.chk_rd = 1'b1; v.exp_rd = e; v.exp_flt = 1'b0;
      return v;
   endfunction

   function automatic vec_t st(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      vec_t v;
      v.we = 1'b1; v.addr = a; v.size = s; v.wd = d;
      v.chk_rd = 1'b0; v.exp_rd = 32'h0; v.exp_flt = 1'b0;
      return v;
   endfunction

   function automatic vec_t fl(input logic w, input logic [31:0] a, input logic [2:0] s,
                               input logic [31:0] d);
      vec_t v;
      v.we = w; v.addr = a; v.size = s; v.wd = d;
      v.chk_rd = 1'b1; v.exp_rd = 32'h0; v.exp_flt = 1'b1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   task automatic req(input bit sel, input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, output logic [31:0] rd, output logic fo,
                      output int lat);
      int n;
      n = 0;
      while (!(sel ? l4_rdy : rdy) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("req_ready_wait", 32'(n < 100), 32'd1);
      if (sel) begin
         l4_valid = 1'b1; l4_we = w; l4_addr = a; l4_size = sz; l4_wd = d;
      end else begin
         valid = 1'b1; we = w; addr = a; size = sz; wd = d;
      end
      @(posedge clk); #1;
      // Scramble request inputs: the response must depend only on captured values.
      if (sel) begin
         l4_valid = 1'b0; l4_we = ~w; l4_addr = ~a; l4_size = SIZE_W; l4_wd = ~d;
      end else begin
         valid = 1'b0; we = ~w; addr = ~a; size = SIZE_W; wd = ~d;
      end
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); #1; lat++;
         if (sel ? l4_rv : rv) break;
      end
      rd = sel ? l4_rdata : rdata;
      fo = sel ? l4_flt : flt_o;
   endtask

   task automatic wait_init(input string nm);
      int  n;
      bit  rdy_seen;
      bit  rv_seen;
      n = 0; rdy_seen = 1'b0; rv_seen = 1'b0;
      while (!l4_init && n < 400) begin
         if (rdy || l4_rdy) rdy_seen = 1'b1;
         if (rv || l4_rv) rv_seen = 1'b1;
         @(posedge clk); #1; n++;
      end
      chk({nm, "_sweep_cycles"}, 32'(n), 32'd256);
      chk({nm, "_ready_low_during_clear"}, 32'(rdy_seen), 32'd0);
      chk({nm, "_no_resp_during_clear"}, 32'(rv_seen), 32'd0);
      chk({nm, "_init_done_l1"}, 32'(init), 32'd1);
      chk({nm, "_ready_after_clear"}, 32'(rdy), 32'd1);
   endtask

   logic [31:0] rd;
   logic        fo;
   int          lat;
   int          lowcnt;

   initial begin
      rst = 1'b1;
      valid = 1'b0; we = 1'b0; addr = 32'h0; wd = 32'h0; size = SIZE_W;
      l4_valid = 1'b0; l4_we = 1'b0; l4_addr = 32'h0; l4_wd = 32'h0; l4_size = SIZE_W;

      vecs.push_back(ld(32'h0000_03FC, SIZE_W, 32'h0000_0000));
      vecs.push_back(st(32'h0000_0010, SIZE_W, 32'h80F0_7F01));
      vecs.push_back(ld(32'h0000_0013, SIZE_B,  32'hFFFF_FF80));
      vecs.push_back(ld(32'h0000_0013, SIZE_BU, 32'h0000_0080));
      vecs.push_back(ld(32'h0000_0012, SIZE_H,  32'hFFFF_80F0));
      vecs.push_back(ld(32'h0000_0012, SIZE_HU, 32'h0000_80F0));
      vecs.push_back(ld(32'h0000_0010, SIZE_B,  32'h0000_0001));
      vecs.push_back(ld(32'h0000_0010, SIZE_HU, 32'h0000_7F01));
      vecs.push_back(ld(32'h0000_0011, SIZE_BU, 32'h0000_007F));
      vecs.push_back(st(32'h0000_0020, SIZE_W, 32'h1122_3344));
      vecs.push_back(st(32'h0000_0021, SIZE_B, 32'hFFFF_FFAB));
      vecs.push_back(ld(32'h0000_0020, SIZE_W, 32'h1122_AB44));
      vecs.push_back(st(32'h0000_0022, SIZE_H, 32'h1234_BEEF));
      vecs.push_back(ld(32'h0000_0020, SIZE_W, 32'hBEEF_AB44));
      vecs.push_back(ld(32'h0000_0010, SIZE_W, 32'h80F0_7F01));
`ifdef BYTE_MEM_ACCESS_FAULT_EN
      vecs.push_back(fl(1'b1, 32'h0000_0002, SIZE_W, 32'h1234_5678));
      vecs.push_back(ld(32'h0000_0000, SIZE_W, 32'h0000_0000));
      vecs.push_back(fl(1'b0, 32'h0000_0011, SIZE_H, 32'h0));
      vecs.push_back(fl(1'b0, 32'h0000_0400, SIZE_W, 32'h0));
      vecs.push_back(fl(1'b0, 32'h0000_0010, 3'b011, 32'h0));
      vecs.push_back(fl(1'b1, 32'h0000_0030, 3'b111, 32'hCAFE_F00D));
      vecs.push_back(ld(32'h0000_0030, SIZE_W, 32'h0000_0000));
      vecs.push_back(fl(1'b1, 32'h0000_0010, SIZE_BU, 32'h0000_00EE));
      vecs.push_back(ld(32'h0000_0010, SIZE_W, 32'h80F0_7F01));
`else
      vecs.push_back(st(32'h0000_0002, SIZE_W, 32'h1234_5678));
      vecs.push_back(ld(32'h0000_0000, SIZE_W, 32'h1234_5678));
      vecs.push_back(ld(32'h0000_0011, SIZE_H, 32'h0000_7F01));
      vecs.push_back(ld(32'h0000_0400, SIZE_W, 32'h1234_5678));
      vecs.push_back(ld(32'h0000_0010, 3'b011, 32'h80F0_7F01));
      vecs.push_back(st(32'h0000_0030, 3'b111, 32'hCAFE_F00D));
      vecs.push_back(ld(32'h0000_0030, SIZE_W, 32'hCAFE_F00D));
`endif

      // Reset values and clear sweep.
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_resp_valid", 32'(rv), 32'd0);
      chk("rst_read_data", rdata, 32'h0);
      chk("rst_fault", 32'(flt_o), 32'd0);
      chk("rst_init_done", 32'(init), 32'd0);
      wait_init("init");

      for (int i = 0; i < vecs.size(); i++) begin
         req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wd, rd, fo, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
         chk($sformatf("v%0d_fault", i), 32'(fo), 32'(vecs[i].exp_flt));
         if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      end

      // READ_LATENCY=4 timing with ReqValid held across two requests.
      req(1'b1, 1'b1, 32'h0000_0040, SIZE_W, 32'hDEAD_BEEF, rd, fo, lat);
      chk("l4_store_latency", 32'(lat), 32'd4);
      l4_valid = 1'b1; l4_we = 1'b0; l4_addr = 32'h0000_0040; l4_size = SIZE_W;
      @(posedge clk); #1;
      lowcnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (!l4_rdy && !l4_rv) lowcnt++;
         @(posedge clk); #1;
      end
      chk("l4_ready_low_cycles", 32'(lowcnt), 32'd4);
      chk("l4_resp_at_t4", 32'(l4_rv), 32'd1);
      chk("l4_ready_at_t4", 32'(l4_rdy), 32'd1);
      chk("l4_rdata", l4_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("l4_resp_single_pulse", 32'(l4_rv), 32'd0);
      chk("l4_second_accept_t5", 32'(l4_rdy), 32'd0);
      l4_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("l4_second_resp_t9", 32'(l4_rv), 32'd1);
      chk("l4_second_rdata", l4_rdata, 32'hDEAD_BEEF);

      // Reset while an LW sits in BUSY: no response, sweep restarts, memory cleared.
      @(posedge clk); #1;
      l4_valid = 1'b1; l4_we = 1'b0; l4_addr = 32'h0000_0040; l4_size = SIZE_W;
      @(posedge clk); #1;
      l4_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("busy_rst_resp_valid", 32'(l4_rv), 32'd0);
      chk("busy_rst_init_done", 32'(l4_init), 32'd0);
      wait_init("rerun");
      req(1'b1, 1'b0, 32'h0000_0040, SIZE_W, 32'h0, rd, fo, lat);
      chk("rerun_l4_rdata", rd, 32'h0);
      chk("rerun_l4_latency", 32'(lat), 32'd4);
      req(1'b0, 1'b0, 32'h0000_0010, SIZE_W, 32'h0, rd, fo, lat);
      chk("rerun_l1_rdata", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
